mips_muldiv: RTL and testbench
==============================

// Module: mips_muldiv
// PURPOSE
//  Iterative integer multiply/divide unit holding the architectural HI/LO registers.
//  Generalises the single-cycle combinational ALU with multi-cycle MULT/MULTU/DIV/DIVU
//  and MTHI/MTLO, and parametrises datapath width.
//  Sits beside the ALU in execute. The core stalls on busy; MFHI/MFLO read hi/lo directly.
// PARAMETERS
//  WIDTH   32  operand/HI/LO width; even, >= 4
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset, synchronous, active-high
//  start         in   1      issue op this cycle
//  op            in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU
//  a             in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
//  b             in   WIDTH  rt operand (multiplier / divisor)
//  flush         in   1      cancel in-flight op (exception squash)
//  busy          out  1      op in flight; start ignored while high
//  done          out  1      one-cycle pulse, the cycle hi/lo show a new mul/div result
//  div_by_zero   out  1      pulses with done when DIV/DIVU had b==0
//  hi            out  WIDTH  HI register
//  lo            out  WIDTH  LO register
// BEHAVIOUR
//  - Reset: state IDLE; hi=lo=0, busy=done=div_by_zero=0, iteration counter=0.
//    Reset mid-op discards all work.
//  - FSM: IDLE -> RUN (WIDTH cycles, one shift-add / restoring-subtract step per cycle)
//    -> FIX (sign correction and commit) -> IDLE.
//  - Start accepted at edge E0 only in IDLE with flush=0.
//    a, b and op are captured at E0; later changes on a/b/op are ignored.
//  - busy=1 for cycles E0..E0+WIDTH+1. At edge E0+WIDTH+1 hi/lo commit, busy falls,
//    and done=1 for exactly that one cycle. Latency is WIDTH+1 cycles.
//  - hi/lo hold their old values throughout RUN/FIX; partial results live in shadow registers.
//  - MTHI/MTLO: hi (or lo) <= a at E0; busy stays 0; no done pulse.
//  - Multiply: {hi,lo} = full 2*WIDTH-bit product.
//    Signed ops run on magnitudes; the product is negated in FIX if the operand signs differ.
//  - Divide: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign.
//    DIV of MIN by -1 gives lo=MIN, hi=0 (wraps, no trap).
//  - b==0 on DIV/DIVU: same latency; hi/lo unchanged; div_by_zero=1 alongside done.
//  - start while busy: ignored, no state change.
//  - flush while busy: next edge returns to IDLE, busy=0, no done, hi/lo unchanged.
//  - flush in IDLE: suppresses any start that cycle. flush always has priority over start.
//  - Op 110/111 are valid only with the macro below; otherwise start is a no-op
//    (busy stays 0, hi/lo unchanged).
// CONFIGURATION
//  - MULDIV_MADD_EN defined: 110 MADD / 111 MADDU do {hi,lo} <= {hi,lo} + a*b
//    (signed / unsigned), with the same latency as MULT.
//    The accumulate reads hi/lo at the commit edge; these values are unchanged since E0.
//  - MULDIV_MADD_EN undefined: no accumulator adder is synthesised;
//    110/111 are treated as no-ops as described above.
// TESTING (WIDTH=32)
//  - MULT a=FFFFFFFD b=00000007 -> 33 cycles later hi=FFFFFFFF lo=FFFFFFEB, done one cycle.
//  - MULTU a=b=FFFFFFFF -> hi=FFFFFFFE lo=00000001.
//  - DIV a=FFFFFFF9 b=2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  - DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//  - DIVU b=0 -> hi/lo unchanged, div_by_zero=1 with done.
//  - MULT issued; extra start at cycle 5 ignored; flush at cycle 10
//    -> busy=0 next cycle, no done, hi/lo keep their prior values.
//  - rst high at cycle 12 of a DIV -> next cycle hi=lo=0, busy=done=0; new MULT then completes normally.
//  - MTLO a=5, MTHI a=0, then MADD a=2 b=3 with macro -> lo=0000000B hi=0.
//    Same sequence without macro -> lo=5, busy never asserted.

Source files
------------

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit that owns HI/LO. Shift-add multiply,
// restoring divide, sign fix and commit, then back to idle.
// Ports: clk, rst (sync, high), start, op[2:0], a, b, flush ->
//   busy, done, div_by_zero, hi, lo.
// MULDIV_MADD_EN enables MADD/MADDU (op 110/111); undefined, they are no-ops.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic            div_q, div_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            bz_q, bz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;
`ifdef MULDIV_MADD_EN
  logic            madd_q, madd_d;
`endif

  logic             is_mthi, is_mtlo, is_go;
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, r2, diff;
  logic [W2-1:0]    mstep, dstep, prod;

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  always_comb begin
    is_mthi = (op == 3'b100);
    is_mtlo = (op == 3'b101);
`ifdef MULDIV_MADD_EN
    is_go   = !op[2] || (op[2:1] == 2'b11);
`else
    is_go   = !op[2];
`endif
    // op[0]==0 selects the signed flavour
    sgn   = !op[0];
    a_neg = sgn && a[WIDTH-1];
    b_neg = sgn && b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // one shift-add multiply step and one restoring divide step
  always_comb begin
    sum   = {1'b0, acc_q[W2-1:WIDTH]}
          + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mstep = {sum, acc_q[WIDTH-1:1]};
    r2    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    diff  = r2 - {1'b0, dvs_q};
    if (!diff[WIDTH])
      dstep = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      dstep = {r2[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    prod    = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_MADD_EN
    madd_d  = madd_q;
    if (madd_q)
      prod = prod + {hi_q, lo_q};
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          unique case (1'b1)
            is_mthi: hi_d = a;
            is_mtlo: lo_d = a;
            is_go: begin
              state_d = S_RUN;
              cnt_d   = '0;
              div_d   = (op[2:1] == 2'b01);
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              bz_d    = (b == '0);
`ifdef MULDIV_MADD_EN
              madd_d  = op[2];
`endif
              // low half holds the operand consumed bit by bit
              if (op[2:1] == 2'b01) begin
                acc_d = {{WIDTH{1'b0}}, a_mag};
                dvs_d = b_mag;
              end else begin
                acc_d = {{WIDTH{1'b0}}, b_mag};
                dvs_d = a_mag;
              end
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = div_q ? dstep : mstep;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CLAST) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!div_q) begin
            hi_d = prod[W2-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (bz_q) begin
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_q ? -acc_q[WIDTH-1:0]
                         : acc_q[WIDTH-1:0];
            hi_d = rneg_q ? -acc_q[W2-1:WIDTH]
                          : acc_q[W2-1:WIDTH];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef MULDIV_MADD_EN
      madd_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef MULDIV_MADD_EN
      madd_q  <= madd_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv (WIDTH=32): reference model of HI/LO,
// expected commits queued at issue and checked on done.
module tb_mips_muldiv;

  localparam int W = 32;
`ifdef MULDIV_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .flush(flush), .busy(busy),
    .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    longint       at;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  longint       cyc = 0;
  logic [W-1:0] m_hi, m_lo;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W:0] model(
    input logic [2:0] o, input logic [W-1:0] x, y, h, l);
    longint        sx, sy, q, r;
    logic [63:0]   p;
    logic [W-1:0]  uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = sx * sy; return {1'b0, p}; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; return {1'b0, p}; end
      3'd2: begin
        if (y == 0) return {1'b1, h, l};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[W-1:0], q[W-1:0]};
      end
      3'd3: begin
        if (y == 0) return {1'b1, h, l};
        uq = x / y;
        ur = x % y;
        return {1'b0, ur, uq};
      end
      3'd4: return {1'b0, x, l};
      3'd5: return {1'b0, h, x};
      3'd6: begin
        p = sx * sy;
        if (MADD) p = p + {h, l};
        return {1'b0, p};
      end
      default: begin
        p = {32'b0, x} * {32'b0, y};
        if (MADD) p = p + {h, l};
        return {1'b0, p};
      end
    endcase
  endfunction

  task automatic issue(input logic [2:0] o,
                       input logic [W-1:0] x, y,
                       input bit track);
    logic [2*W:0] r;
    exp_t         e;
    bit           long_op;
    long_op = (o[2] == 1'b0) || (MADD && o[2:1] == 2'b11);
    r = model(o, x, y, m_hi, m_lo);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (track) begin
      if (long_op) begin
        e.hi  = r[2*W-1:W];
        e.lo  = r[W-1:0];
        e.dbz = r[2*W];
        e.at  = cyc + W + 2;
        sb.push_back(e);
      end
      if (long_op || o[2:1] == 2'b10) begin
        m_hi = r[2*W-1:W];
        m_lo = r[W-1:0];
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("busy_timeout", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {63'b0, done}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, e.hi});
        chk("lo", {32'b0, lo}, {32'b0, e.lo});
        chk("dbz", {63'b0, div_by_zero}, {63'b0, e.dbz});
        chk("latency", cyc, e.at);
        chk("busy_at_done", {63'b0, busy}, 64'd0);
      end
    end else if (div_by_zero !== 1'b0) begin
      chk("dbz_no_done", {63'b0, div_by_zero}, 64'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish at time %0t", $time);
    $fatal(1);
  end

  logic [W-1:0] ph, pl;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dbz", {63'b0, div_by_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    issue(3'd4, 32'h1234_5678, 32'h0, 1'b1);
    chk("mthi", {32'b0, hi}, 64'h1234_5678);
    chk("mt_busy", {63'b0, busy}, 64'd0);
    issue(3'd5, 32'h9abc_def0, 32'h0, 1'b1);
    chk("mtlo", {32'b0, lo}, 64'h9abc_def0);

    ph = m_hi; pl = m_lo;
    issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
    chk("run_busy0", {63'b0, busy}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("run_busy", {63'b0, busy}, 64'd1);
    chk("run_hold", {hi, lo}, {ph, pl});
    wait_idle();
    chk("mult_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    chk("multu_vec", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b1);
    wait_idle();
    chk("div_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    chk("div_min", {hi, lo}, 64'h0000_0000_8000_0000);

    issue(3'd1, 32'h0000_0123, 32'h0000_0456, 1'b1);
    wait_idle();
    issue(3'd3, 32'hDEAD_BEEF, 32'h0, 1'b1);
    wait_idle();
    issue(3'd2, 32'h8000_0001, 32'h0, 1'b1);
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] rx, ry;
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 4 == 1) ry = -ry;
      issue(ro, rx, ry, 1'b1);
      wait_idle();
    end

    // flush mid-op, with a stray start while busy
    ph = m_hi; pl = m_lo;
    issue(3'd0, 32'h7, 32'h9, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = 3'd5; a = 32'h5555; b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_ignore_start", {32'b0, lo}, {32'b0, pl});
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_hold", {hi, lo}, {ph, pl});
    repeat (W + 5) @(posedge clk);
    #1;
    chk("flush_hold_late", {hi, lo}, {ph, pl});

    // flush in idle beats start
    flush = 1'b1;
    issue(3'd5, 32'hDEAD, 32'h0, 1'b0);
    chk("idle_flush_mt", {32'b0, lo}, {32'b0, pl});
    issue(3'd0, 32'h3, 32'h3, 1'b0);
    flush = 1'b0;
    chk("idle_flush_busy", {63'b0, busy}, 64'd0);

    // reset in the middle of a divide
    issue(3'd2, 32'h0000_1000, 32'h7, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_hi = '0; m_lo = '0;
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    issue(3'd0, 32'hFFFF_0000, 32'h0001_0000, 1'b1);
    wait_idle();
    chk("post_rst_mult", {hi, lo}, 64'hFFFF_FFFF_0000_0000);

    // accumulate
    issue(3'd5, 32'h5, 32'h0, 1'b1);
    issue(3'd4, 32'h0, 32'h0, 1'b1);
    issue(3'd6, 32'h2, 32'h3, 1'b1);
`ifdef MULDIV_MADD_EN
    wait_idle();
    chk("madd", {hi, lo}, 64'h0000_0000_0000_000B);
    issue(3'd6, 32'hFFFF_FFFF, 32'h4, 1'b1);
    wait_idle();
    issue(3'd7, 32'hFFFF_FFFF, 32'h2, 1'b1);
    wait_idle();
`else
    chk("madd_off_busy", {63'b0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("madd_off_busy2", {63'b0, busy}, 64'd0);
    chk("madd_off_hilo", {hi, lo}, 64'h0000_0000_0000_0005);
    issue(3'd7, 32'h2, 32'h3, 1'b1);
    chk("maddu_off_busy", {63'b0, busy}, 64'd0);
`endif

    repeat (W + 5) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
